// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
//   estado_t  : scan FSM states (GUARDA = dead time, EXIBE = digit lit)
//   nibble_t  : one hex digit as fed to the decoder
//   ANODO_OFF : all anodes released (active-low); slice to N_DIG bits at use
package display_pkg;

  typedef enum logic {GUARDA = 1'b0, EXIBE = 1'b1} estado_t;

  typedef logic [3:0] nibble_t;

  // Widest supported display is 8 digits; callers take the low N_DIG bits.
  localparam logic [7:0] ANODO_OFF = 8'hFF;

endpackage

// File: rtl/display_varredura_divisor.sv
// divisor_refresh: terminal-count counter shared by the lit and dead-time
// phases. Counts 0..limite, flags fim while at limite.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear (takes priority over counting)
//   limite     : terminal count for the current phase
//   fim        : high during the cycle the count equals limite
module divisor_refresh #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + W'(1);
  end

  assign fim = (cnt == limite);

endmodule

// File: rtl/display_varredura.sv
// display_varredura: scan controller for a common-anode N_DIG-digit display.
// Lights one digit per slot of PRESCALE cycles, separated by BLANK_CYC cycles
// of all-anodes-off, loads new values only at frame boundaries and can blank
// leading zeros.
//   clk, reset : clock, async active-high reset
//   valor      : packed hex value, digit i = valor[4i+3:4i]
//   carga      : valid for valor; accepted when carga && pronto
//   pronto     : ready (no load waiting for the frame boundary)
//   supr_zero  : blank leading zero digits (digit 0 always shown)
//   digito     : nibble for the decoder
//   anodo      : active-low digit enables, at most one low
//   indice     : digit currently addressed
//   apagado    : all anodes off this cycle
module display_varredura
  import display_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4*N_DIG-1:0]         valor,
  input  logic                       carga,
  output logic                       pronto,
  input  logic                       supr_zero,
  output nibble_t                    digito,
  output logic [N_DIG-1:0]           anodo,
  output logic [$clog2(N_DIG)-1:0]   indice,
  output logic                       apagado
);

  localparam int IW   = $clog2(N_DIG);
  localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);

  estado_t              estado, estado_nx;
  logic [CW-1:0]        limite;
  logic                 fim;
  logic [4*N_DIG-1:0]   disp, disp_nx, pend;
  logic                 pend_vld;
  logic [IW-1:0]        ind_nx;
  logic                 wrap;
  logic                 aceita;
  logic                 suprime;
  logic                 zeros;
  logic [N_DIG-1:0]     an_on;
  nibble_t              dig_nx;

  // Same counter serves both phases; the limit follows the current state and
  // the counter clears itself on its own terminal count.
  assign limite = (estado == EXIBE) ? CW'(PRESCALE - 1) : CW'(BLANK_CYC - 1);

  divisor_refresh #(.W(CW)) u_div (
    .clk    (clk),
    .reset  (reset),
    .clr    (fim),
    .limite (limite),
    .fim    (fim)
  );

  assign pronto = ~pend_vld;
  assign aceita = carga & ~pend_vld;

  always_comb begin
    estado_nx = estado;
    ind_nx    = indice;
    wrap      = 1'b0;
    if (fim) begin
      case (estado)
        GUARDA: estado_nx = EXIBE;
        EXIBE: begin
          estado_nx = GUARDA;
          wrap      = (indice == IW'(N_DIG - 1));
          ind_nx    = wrap ? '0 : indice + IW'(1);
        end
        default: estado_nx = GUARDA;
      endcase
    end
  end

  // A pending value replaces the whole display only as indice wraps, so a
  // frame never mixes two values.
  assign disp_nx = (wrap && pend_vld) ? pend : disp;

  // Digit i>0 is blanked when it and every more significant digit are zero.
  always_comb begin
    zeros   = 1'b1;
    suprime = 1'b0;
    for (int i = N_DIG - 1; i > 0; i--) begin
      zeros = zeros & (disp[4*i +: 4] == 4'h0);
      if (indice == IW'(i)) suprime = supr_zero & zeros;
    end
  end

  always_comb begin
    dig_nx = '0;
    an_on  = '1;
    for (int i = 0; i < N_DIG; i++) begin
      if (ind_nx == IW'(i)) dig_nx = disp_nx[4*i +: 4];
      an_on[i] = (indice != IW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= GUARDA;
      indice   <= '0;
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      digito   <= '0;
      anodo    <= ANODO_OFF[N_DIG-1:0];
      apagado  <= 1'b1;
    end else begin
      estado <= estado_nx;
      indice <= ind_nx;
      disp   <= disp_nx;
      digito <= dig_nx;

      if (wrap && pend_vld) pend_vld <= 1'b0;
      else if (aceita) begin
        pend     <= valor;
        pend_vld <= 1'b1;
      end

      // Suppression is decided once, on entry to the lit phase, so a change
      // of supr_zero never cuts a slot short.
      if (fim && estado == GUARDA) begin
        anodo   <= suprime ? ANODO_OFF[N_DIG-1:0] : an_on;
        apagado <= suprime;
      end else if (fim && estado == EXIBE) begin
        anodo   <= ANODO_OFF[N_DIG-1:0];
        apagado <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_varredura.sv
module tb_display_varredura;
  localparam int N = 4, P = 4, B = 1;
  localparam int SLOT = P + B, FRAME = N * SLOT;

  logic        clk = 1'b0, reset = 1'b1, carga = 1'b0, supr_zero = 1'b0;
  logic [15:0] valor = '0;
  logic        pronto, apagado;
  logic [3:0]  digito, anodo;
  logic [1:0]  indice;

  always #5 clk = ~clk;

  display_varredura #(.N_DIG(N), .PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk(clk), .reset(reset), .valor(valor), .carga(carga), .pronto(pronto),
    .supr_zero(supr_zero), .digito(digito), .anodo(anodo), .indice(indice),
    .apagado(apagado)
  );

  // Reference model: position in the frame follows from the cycle count alone.
  int          t;
  logic [15:0] disp_m, pend_m;
  bit          pend_v, lit_ok;
  logic [3:0]  obs_mask;
  int          checks = 0, passed = 0;

  typedef struct {
    logic [15:0] valor;
    logic        supr;
    logic [3:0]  mask;
  } vec_t;
  vec_t tab[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s t=%0d got=%0h want=%0h", name, t, got, exp);
  endtask

  task automatic check_cycle();
    int s, o;
    logic [3:0] ea;
    s  = (t / SLOT) % N;
    o  = t % SLOT;
    ea = (o >= B && lit_ok) ? ~(4'b0001 << s) : 4'hF;
    chk("anodo", anodo, ea);
    chk("apagado", apagado, (ea == 4'hF));
    chk("indice", indice, s);
    chk("digito", digito, (disp_m >> (4 * s)) & 16'hF);
    chk("pronto", pronto, !pend_v);
    chk("onehot", ($countones(~anodo) <= 1) && (o >= B || anodo == 4'hF), 1);
    obs_mask = obs_mask | ~anodo;
  endtask

  task automatic model_edge();
    int s;
    s = (t / SLOT) % N;
    if (t % SLOT == B - 1)
      lit_ok = !(s > 0 && supr_zero && ((disp_m >> (4 * s)) == 0));
    if (t % FRAME == FRAME - 1 && pend_v) begin
      disp_m = pend_m;
      pend_v = 0;
    end else if (carga && !pend_v) begin
      pend_m = valor;
      pend_v = 1;
    end
    t++;
  endtask

  task automatic cyc(input logic c, input logic [15:0] v, input logic z);
    check_cycle();
    carga = c; valor = v; supr_zero = z;
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (t < target) cyc(1'b0, valor, supr_zero);
  endtask

  task automatic model_reset();
    t = 0; disp_m = '0; pend_v = 0; lit_ok = 0;
  endtask

  initial begin
    int seen7;
    tab[0] = '{16'h0070, 1'b1, 4'b0011};
    tab[1] = '{16'h0000, 1'b1, 4'b0001};
    tab[2] = '{16'h0100, 1'b1, 4'b0111};
    tab[3] = '{16'h8000, 1'b1, 4'b1111};
    tab[4] = '{16'h1234, 1'b0, 4'b1111};
    tab[5] = '{16'h0000, 1'b0, 4'b1111};
    tab[6] = '{16'h0005, 1'b1, 4'b0001};
    obs_mask = '0;

    // Reset values
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_anodo", anodo, 4'hF);
    chk("rst_digito", digito, 0);
    chk("rst_indice", indice, 0);
    chk("rst_apagado", apagado, 1);
    chk("rst_pronto", pronto, 1);

    // Load 1234 in cycle 0
    cyc(1'b1, 16'h1234, 1'b0);
    chk("load_pronto_low", pronto, 0);
    chk("old_dig0", digito, 0);
    chk("old_an0", anodo, 4'hE);
    run_to(20); chk("pronto_back", pronto, 1);
    run_to(21); chk("f1_d0", digito, 4); chk("f1_a0", anodo, 4'hE);
    run_to(26); chk("f1_d1", digito, 3); chk("f1_a1", anodo, 4'hD);
    run_to(31); chk("f1_d2", digito, 2); chk("f1_a2", anodo, 4'hB);
    run_to(36); chk("f1_d3", digito, 1); chk("f1_a3", anodo, 4'h7);

    // ABCD accepted, 5555 offered while not ready and ignored
    cyc(1'b1, 16'hABCD, 1'b0);
    chk("nomix_old", digito, 1);
    repeat (3) cyc(1'b1, 16'h5555, 1'b0);
    run_to(41); chk("f2_d0", digito, 4'hD);
    run_to(46); chk("f2_d1", digito, 4'hC);
    run_to(51); chk("f2_d2", digito, 4'hB);
    run_to(56); chk("f2_d3", digito, 4'hA);
    run_to(61); chk("f3_d0", digito, 4'hD);
    run_to(81); chk("f4_d0", digito, 4'hD);

    // Leading-zero suppression table
    for (int r = 0; r < 7; r++) begin
      int k;
      cyc(1'b1, tab[r].valor, tab[r].supr);
      k = 0;
      while (!(t % FRAME == 0 && !pend_v) && k < 60) begin
        cyc(1'b0, tab[r].valor, tab[r].supr);
        k++;
      end
      chk("tab_sync", k < 60, 1);
      obs_mask = '0;
      repeat (FRAME) cyc(1'b0, tab[r].valor, tab[r].supr);
      chk("lit_mask", obs_mask, tab[r].mask);
    end

    // carga exactly in the wrap cycle: applied one frame later
    begin
      int k;
      k = 0;
      while (t % FRAME != FRAME - 1 && k < 40) begin
        cyc(1'b0, valor, 1'b0);
        k++;
      end
    end
    chk("wrap_ready", pronto, 1);
    cyc(1'b1, 16'h9876, 1'b0);
    cyc(1'b0, 16'h9876, 1'b0);
    chk("wrap_old", digito, 5);
    chk("wrap_pend", pronto, 0);
    repeat (FRAME) cyc(1'b0, 16'h9876, 1'b0);
    chk("wrap_new", digito, 6);
    chk("wrap_new_an", anodo, 4'hE);

    // Reset mid-lit slot with a load pending
    cyc(1'b1, 16'h7777, 1'b0);
    cyc(1'b0, 16'h7777, 1'b0);
    chk("pre_rst_lit", apagado, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_anodo", anodo, 4'hF);
    chk("mid_rst_pronto", pronto, 1);
    chk("mid_rst_indice", indice, 0);
    chk("mid_rst_apagado", apagado, 1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    seen7 = 0;
    repeat (60) begin
      if (digito == 4'h7) seen7++;
      cyc(1'b0, 16'h0000, 1'b0);
    end
    chk("no_stale_pend", seen7, 0);

    // Random traffic against the model
    repeat (400) begin
      logic c, z;
      c = ($urandom_range(0, 3) == 0);
      z = ($urandom_range(0, 15) == 0) ? ~supr_zero : supr_zero;
      cyc(c, 16'($urandom), z);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
